// File: rtl/trig_delay_multi.sv
// Multi-channel trigger delay: per-channel rising-edge detect, programmable delay and pulse width.
// Optional missed-trigger counters are built when TRIG_DELAY_MISS_CNT_EN is defined.
module trig_delay_multi #(
    parameter int unsigned NCH     = 4,
    parameter int unsigned DELAY_W = 8,
    parameter int unsigned WIDTH_W = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         en,
    input  logic                   retrig_mode,
    input  logic [NCH-1:0]         trig_in,
    input  logic [NCH*DELAY_W-1:0] delay,
    input  logic [NCH*WIDTH_W-1:0] width,
    output logic [NCH-1:0]         trig_out,
    output logic [NCH-1:0]         busy
`ifdef TRIG_DELAY_MISS_CNT_EN
    ,
    output logic [NCH*CNT_W-1:0]   miss_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_PULSE
    } state_t;

    state_t             state_q [NCH];
    state_t             state_d [NCH];
    logic [DELAY_W-1:0] cnt_q   [NCH];
    logic [DELAY_W-1:0] cnt_d   [NCH];
    logic [DELAY_W-1:0] dlat_q  [NCH];
    logic [DELAY_W-1:0] dlat_d  [NCH];
    logic [WIDTH_W-1:0] pcnt_q  [NCH];
    logic [WIDTH_W-1:0] pcnt_d  [NCH];
    logic [WIDTH_W-1:0] wlat_q  [NCH];
    logic [WIDTH_W-1:0] wlat_d  [NCH];
    logic [DELAY_W-1:0] d_new   [NCH];
    logic [WIDTH_W-1:0] w_new   [NCH];

    logic [NCH-1:0] trig_q;
    logic [NCH-1:0] rise;
    logic [NCH-1:0] trig_out_d;
    logic [NCH-1:0] busy_d;

`ifdef TRIG_DELAY_MISS_CNT_EN
    logic [CNT_W-1:0] miss_q [NCH];
    logic [CNT_W-1:0] miss_d [NCH];
`endif

    always_comb begin
        rise = trig_in & ~trig_q;
        for (int unsigned i = 0; i < NCH; i++) begin
            d_new[i] = delay[i*DELAY_W +: DELAY_W];
            // A zero width still produces a one-cycle pulse.
            w_new[i] = (width[i*WIDTH_W +: WIDTH_W] == '0) ? WIDTH_W'(1)
                                                           : width[i*WIDTH_W +: WIDTH_W];
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            dlat_d[i]  = dlat_q[i];
            pcnt_d[i]  = pcnt_q[i];
            wlat_d[i]  = wlat_q[i];
`ifdef TRIG_DELAY_MISS_CNT_EN
            miss_d[i]  = miss_q[i];
`endif
            if (!en[i]) begin
                state_d[i] = S_IDLE;
            end else if (rise[i] && (state_q[i] == S_IDLE || retrig_mode)) begin
                dlat_d[i]  = d_new[i];
                wlat_d[i]  = w_new[i];
                cnt_d[i]   = DELAY_W'(1);
                pcnt_d[i]  = WIDTH_W'(1);
                state_d[i] = (d_new[i] == '0) ? S_PULSE : S_DELAY;
            end else begin
                // Any rise reaching here hit a busy channel, including the final PULSE cycle.
`ifdef TRIG_DELAY_MISS_CNT_EN
                if (rise[i] && miss_q[i] != '1) begin
                    miss_d[i] = miss_q[i] + CNT_W'(1);
                end
`endif
                case (state_q[i])
                    S_DELAY: begin
                        if (cnt_q[i] == dlat_q[i]) begin
                            state_d[i] = S_PULSE;
                            pcnt_d[i]  = WIDTH_W'(1);
                        end else begin
                            cnt_d[i] = cnt_q[i] + DELAY_W'(1);
                        end
                    end
                    S_PULSE: begin
                        if (pcnt_q[i] == wlat_q[i]) begin
                            state_d[i] = S_IDLE;
                        end else begin
                            pcnt_d[i] = pcnt_q[i] + WIDTH_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
            trig_out_d[i] = (state_d[i] == S_PULSE);
            busy_d[i]     = (state_d[i] != S_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            trig_q   <= '0;
            trig_out <= '0;
            busy     <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= '0;
                dlat_q[i]  <= '0;
                pcnt_q[i]  <= '0;
                wlat_q[i]  <= '0;
`ifdef TRIG_DELAY_MISS_CNT_EN
                miss_q[i]  <= '0;
`endif
            end
        end else begin
            trig_q   <= trig_in;
            trig_out <= trig_out_d;
            busy     <= busy_d;
            for (int unsigned i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                dlat_q[i]  <= dlat_d[i];
                pcnt_q[i]  <= pcnt_d[i];
                wlat_q[i]  <= wlat_d[i];
`ifdef TRIG_DELAY_MISS_CNT_EN
                miss_q[i]  <= miss_d[i];
`endif
            end
        end
    end

`ifdef TRIG_DELAY_MISS_CNT_EN
    always_comb begin
        miss_cnt = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            miss_cnt[i*CNT_W +: CNT_W] = miss_q[i];
        end
    end
`endif

endmodule

// File: doc/trig_delay_multi.md
Name: trig_delay_multi

Overview:
Parametrised, multi-channel successor to the single-channel trigger delay. Each of NCH channels detects a rising edge on its trigger input and emits a pulse of programmable width after a programmable delay. Channels have a per-channel enable, a busy flag, and a global retrigger policy. Sits between the trigger-distribution logic and the SFP/readout trigger consumers.

Parameters:
NCH, 4, number of independent trigger channels
DELAY_W, 8, width of each channel's delay field (cycles)
WIDTH_W, 4, width of each channel's pulse-width field (cycles)
CNT_W, 16, width of each missed-trigger counter (optional feature only)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (asserted when 0)
en  in  NCH  per-channel enable
retrig_mode  in  1  0 = ignore triggers while busy; 1 = restart on new trigger
trig_in  in  NCH  trigger inputs, one per channel, synchronous to clk
delay  in  NCH*DELAY_W  per-channel delay D; channel i uses bits [i*DELAY_W +: DELAY_W]
width  in  NCH*WIDTH_W  per-channel pulse width W; channel i uses bits [i*WIDTH_W +: WIDTH_W]
trig_out  out  NCH  delayed trigger pulses, registered
busy  out  NCH  channel in DELAY or PULSE state, registered
miss_cnt  out  NCH*CNT_W  missed-trigger counters (present only with TRIG_DELAY_MISS_CNT_EN)

Behaviour:
- Reset (rst==0 at a clk edge): all channels go to IDLE; trig_out=0, busy=0, edge-detect history=0, internal counters=0, miss_cnt=0.
- Edge detect: per channel, rise = trig_in & ~trig_q; trig_q is trig_in registered. A level held high produces exactly one rise.
- Per-channel FSM: IDLE, DELAY, PULSE.
- IDLE: on rise with en=1 at edge E0, latch D and W (W==0 treated as 1). If D==0, go to PULSE and set trig_out=1 at E0. Otherwise go to DELAY with cnt=1; busy=1 from E0.
- DELAY: cnt increments each edge; when cnt==D at an edge, go to PULSE and set trig_out=1. trig_out therefore rises at edge E0+D.
- PULSE: trig_out stays 1 for exactly W cycles (cleared at edge E0+D+W), then IDLE with busy=0.
- Latched D/W are used for the whole operation; changes to delay/width mid-operation have no effect until the next accepted trigger.
- Rise while busy, retrig_mode=0: ignored, and counted as a miss.
- Rise while busy, retrig_mode=1: operation restarts exactly as from IDLE at that edge. New D/W are latched, and trig_out=0 unless the new D==0. No miss is counted.
- Rise in the same cycle that PULSE finishes: treated as a rise while busy.
- en=0: the channel goes to IDLE at the next edge with trig_out=0 and busy=0. Rises are ignored and never counted as misses. trig_q keeps tracking trig_in.
- Channels are fully independent; no shared arbitration.
- Counters are sized DELAY_W/WIDTH_W; no wrap occurs because the terminal compare precedes overflow (D max = 2^DELAY_W-1).

Optional Feature:
Macro TRIG_DELAY_MISS_CNT_EN.
- Defined: miss_cnt port exists. Each channel's counter increments by 1 per ignored rise (retrig_mode=0, busy, en=1) and saturates at 2^CNT_W-1. It clears only on reset.
- Undefined: the miss_cnt port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset release; ch0 D=5, W=3, single rise at edge 10 -> trig_out[0] high at edges 15-17 and low at 18; busy[0] high edges 10-17.
- ch1 D=0, W=0 -> trig_out[1] high for exactly 1 cycle starting at the rise edge.
- retrig_mode=0, ch2 D=10, W=2, second rise 4 cycles after the first -> single pulse at first+10; miss_cnt[2]=1 (macro on).
- retrig_mode=1, same stimulus -> single pulse at second+10; none at first+10; miss_cnt[2]=0.
- trig_in held high 50 cycles, D=3, W=1 -> exactly one pulse; delay changed to 7 mid-DELAY -> pulse still at +3.
- rst driven to 0 mid-PULSE on ch3, and en[0]=0 mid-DELAY -> trig_out/busy low next edge; no later pulse.
